// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage RV32I pipeline.
// Captures decoded ID fields and the extended immediate for EX. It also
// detects load-use hazards: it inserts one bubble and stalls ID for that
// cycle. EX back-pressure holds the register. A branch flush kills its contents.
// A saturating counter records how many load-use bubbles were inserted.
module id_ex_pipe_reg #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_rs1_data,
    input  logic [31:0]       id_rs2_data,
    input  logic [31:0]       id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_ready,
    input  logic              ex_flush,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_rs1_data,
    output logic [31:0]       ex_rs2_data,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              ex_valid_q,     ex_valid_d;
    logic [31:0]       ex_pc_q,        ex_pc_d;
    logic [31:0]       ex_rs1_data_q,  ex_rs1_data_d;
    logic [31:0]       ex_rs2_data_q,  ex_rs2_data_d;
    logic [31:0]       ex_imm_q,       ex_imm_d;
    logic [4:0]        ex_rs1_q,       ex_rs1_d;
    logic [4:0]        ex_rs2_q,       ex_rs2_d;
    logic [4:0]        ex_rd_q,        ex_rd_d;
    logic              ex_mem_read_q,  ex_mem_read_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic [CTRL_W-1:0] ex_ctrl_q,      ex_ctrl_d;
    logic [CNT_W-1:0]  bubble_cnt_q,   bubble_cnt_d;

    logic hold;
    logic hazard;
    logic rs1_match;
    logic rs2_match;

    // Hazard and back-pressure detection, and the ID handshake.
    // A load to x0 never produces a hazard. Only a valid load in EX can stall ID.
    always_comb begin
        rs1_match = id_use_rs1 && (id_rs1 == ex_rd_q);
        rs2_match = id_use_rs2 && (id_rs2 == ex_rd_q);
        hold      = ex_valid_q && !ex_ready;
        hazard    = ex_valid_q && ex_mem_read_q && (ex_rd_q != 5'd0) &&
                    id_valid && (rs1_match || rs2_match);
        id_ready  = ex_flush || (!hold && !hazard);
    end

    // Next-state selection. The priority is flush, then hold, then hazard
    // bubble, then normal capture.
    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_pc_d        = ex_pc_q;
        ex_rs1_data_d  = ex_rs1_data_q;
        ex_rs2_data_d  = ex_rs2_data_q;
        ex_imm_d       = ex_imm_q;
        ex_rs1_d       = ex_rs1_q;
        ex_rs2_d       = ex_rs2_q;
        ex_rd_d        = ex_rd_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_ctrl_d      = ex_ctrl_q;
        bubble_cnt_d   = bubble_cnt_q;

        if (ex_flush || (!hold && hazard)) begin
            ex_valid_d     = 1'b0;
            ex_pc_d        = '0;
            ex_rs1_data_d  = '0;
            ex_rs2_data_d  = '0;
            ex_imm_d       = '0;
            ex_rs1_d       = '0;
            ex_rs2_d       = '0;
            ex_rd_d        = '0;
            ex_mem_read_d  = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_ctrl_d      = '0;
            // Flush takes precedence, so a bubble is counted only when it was caused by a hazard.
            if (!ex_flush && (bubble_cnt_q != {CNT_W{1'b1}})) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else if (!hold) begin
            ex_valid_d     = id_valid;
            ex_pc_d        = id_pc;
            ex_rs1_data_d  = id_rs1_data;
            ex_rs2_data_d  = id_rs2_data;
            ex_imm_d       = id_imm;
            ex_rs1_d       = id_rs1;
            ex_rs2_d       = id_rs2;
            ex_rd_d        = id_rd;
            // An empty slot must not carry side-effecting control into EX.
            ex_mem_read_d  = id_valid && id_mem_read;
            ex_reg_write_d = id_valid && id_reg_write;
            ex_ctrl_d      = id_valid ? id_ctrl : '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_pc_q        <= '0;
            ex_rs1_data_q  <= '0;
            ex_rs2_data_q  <= '0;
            ex_imm_q       <= '0;
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
            ex_rd_q        <= '0;
            ex_mem_read_q  <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_ctrl_q      <= '0;
            bubble_cnt_q   <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_pc_q        <= ex_pc_d;
            ex_rs1_data_q  <= ex_rs1_data_d;
            ex_rs2_data_q  <= ex_rs2_data_d;
            ex_imm_q       <= ex_imm_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_rd_q        <= ex_rd_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_ctrl_q      <= ex_ctrl_d;
            bubble_cnt_q   <= bubble_cnt_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_pc        = ex_pc_q;
    assign ex_rs1_data  = ex_rs1_data_q;
    assign ex_rs2_data  = ex_rs2_data_q;
    assign ex_imm       = ex_imm_q;
    assign ex_rs1       = ex_rs1_q;
    assign ex_rs2       = ex_rs2_q;
    assign ex_rd        = ex_rd_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_ctrl      = ex_ctrl_q;
    assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Testbench for id_ex_pipe_reg.
// A behavioural model runs alongside the DUT and is compared on every falling edge.
// Directed scenarios first, then randomized traffic.
// The counter is built 4 bits wide so saturation can be reached.
module tb_id_ex_pipe_reg;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid, id_ready;
    logic [31:0]       id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic              id_use_rs1, id_use_rs2, id_mem_read, id_reg_write;
    logic [CTRL_W-1:0] id_ctrl;
    logic              ex_ready, ex_flush, ex_valid;
    logic [31:0]       ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic              ex_mem_read, ex_reg_write;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_pipe_reg #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .id_ctrl(id_ctrl),
        .ex_ready(ex_ready), .ex_flush(ex_flush), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_ctrl(ex_ctrl),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the EX register contents.
    logic              m_valid = 1'b0, m_mr = 1'b0, m_rw = 1'b0;
    logic [31:0]       m_pc = '0, m_d1 = '0, m_d2 = '0, m_imm = '0;
    logic [4:0]        m_rs1 = '0, m_rs2 = '0, m_rd = '0;
    logic [CTRL_W-1:0] m_ctrl = '0;
    int                m_cnt = 0;

    function automatic bit m_hold();
        return m_valid && !ex_ready;
    endfunction

    function automatic bit m_hazard();
        return m_valid && m_mr && (m_rd != 0) && id_valid &&
               ((id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd));
    endfunction

    task automatic m_clear();
        m_valid = 0; m_mr = 0; m_rw = 0; m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_clear();
            m_cnt = 0;
        end else if (ex_flush) begin
            m_clear();
        end else if (m_hold()) begin
            // Contents are frozen while EX is stalled.
        end else if (m_hazard()) begin
            m_clear();
            m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end else begin
            m_valid = id_valid;
            m_pc = id_pc; m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            m_mr = id_valid & id_mem_read;
            m_rw = id_valid & id_reg_write;
            m_ctrl = id_valid ? id_ctrl : '0;
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        check("ex_valid", 64'(ex_valid), 64'(m_valid));
        check("ex_mem_read", 64'(ex_mem_read), 64'(m_mr));
        check("ex_reg_write", 64'(ex_reg_write), 64'(m_rw));
        check("ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
        check("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
        check("id_ready", 64'(id_ready), 64'(ex_flush || (!m_hold() && !m_hazard())));
        if (m_valid) begin
            check("ex_pc", 64'(ex_pc), 64'(m_pc));
            check("ex_rs1_data", 64'(ex_rs1_data), 64'(m_d1));
            check("ex_rs2_data", 64'(ex_rs2_data), 64'(m_d2));
            check("ex_imm", 64'(ex_imm), 64'(m_imm));
            check("ex_idx", 64'({ex_rs1, ex_rs2, ex_rd}), 64'({m_rs1, m_rs2, m_rd}));
        end
    end

    task automatic set_instr(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                             input logic u2, input logic mr, input logic rw, input logic [31:0] imm);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_mem_read = mr; id_reg_write = rw; id_imm = imm;
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_ctrl = CTRL_W'($urandom);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_id();
        id_valid = ($urandom % 4) != 0;
        id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_rs1 = 5'($urandom % 4); id_rs2 = 5'($urandom % 4); id_rd = 5'($urandom % 4);
        id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
        id_mem_read = ($urandom % 3) == 0; id_reg_write = 1'($urandom);
        id_ctrl = CTRL_W'($urandom);
    endtask

    initial begin
        rst = 1; ex_ready = 1; ex_flush = 0;
        randomize_id();
        // Reset for two cycles while ID carries random traffic.
        next_cycle(); randomize_id();
        next_cycle();
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_ex_pc", 64'(ex_pc), 64'd0);
        check("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
        rst = 0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("rst_id_ready", 64'(id_ready), 64'd1);

        // ADDI x5, pc 0x100, imm -16.
        set_instr(1, 32'h100, 5'd1, 5'd0, 5'd5, 1, 0, 0, 1, 32'hFFFF_FFF0);
        next_cycle();
        check("addi_valid", 64'(ex_valid), 64'd1);
        check("addi_pc", 64'(ex_pc), 64'h100);
        check("addi_imm", 64'(ex_imm), 64'hFFFF_FFF0);
        check("addi_rd", 64'(ex_rd), 64'd5);

        // LW x7 followed by a dependent ADD.
        set_instr(1, 32'h104, 5'd2, 5'd0, 5'd7, 1, 0, 1, 1, 32'd8);
        next_cycle();
        set_instr(1, 32'h108, 5'd7, 5'd3, 5'd9, 1, 1, 0, 1, 32'd0);
        #1 check("lu_id_ready", 64'(id_ready), 64'd0);
        next_cycle();
        check("lu_bubble_valid", 64'(ex_valid), 64'd0);
        check("lu_bubble_pc", 64'(ex_pc), 64'd0);
        check("lu_bubble_rd", 64'(ex_rd), 64'd0);
        check("lu_bubble_cnt", 64'(bubble_cnt), 64'd1);
        check("lu_id_ready_after", 64'(id_ready), 64'd1);
        next_cycle();
        check("lu_add_valid", 64'(ex_valid), 64'd1);
        check("lu_add_pc", 64'(ex_pc), 64'h108);

        // A load to x0 never stalls.
        set_instr(1, 32'h10C, 5'd2, 5'd0, 5'd0, 1, 0, 1, 1, 32'd4);
        next_cycle();
        set_instr(1, 32'h110, 5'd0, 5'd0, 5'd4, 1, 0, 0, 1, 32'd0);
        #1 check("x0_id_ready", 64'(id_ready), 64'd1);
        next_cycle();
        check("x0_add_pc", 64'(ex_pc), 64'h110);
        check("x0_bubble_cnt", 64'(bubble_cnt), 64'd1);

        // Back-pressure for three cycles, then a flush while holding.
        set_instr(1, 32'h200, 5'd1, 5'd2, 5'd6, 1, 1, 0, 1, 32'd12);
        next_cycle();
        ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            randomize_id();
            #1 check("hold_id_ready", 64'(id_ready), 64'd0);
            next_cycle();
            check("hold_pc", 64'(ex_pc), 64'h200);
            check("hold_imm", 64'(ex_imm), 64'd12);
        end
        ex_flush = 1;
        next_cycle();
        check("flush_valid", 64'(ex_valid), 64'd0);
        check("flush_reg_write", 64'(ex_reg_write), 64'd0);
        ex_flush = 0; ex_ready = 1;

        // Load-use pairs until the counter saturates.
        for (int i = 0; i < 20; i++) begin
            set_instr(1, 32'h300, 5'd1, 5'd0, 5'd3, 1, 0, 1, 1, 32'd0);
            next_cycle();
            set_instr(1, 32'h304, 5'd1, 5'd3, 5'd8, 0, 1, 0, 1, 32'd0);
            next_cycle();
            next_cycle();
        end
        check("sat_bubble_cnt", 64'(bubble_cnt), 64'd15);

        // Randomized traffic with occasional reset, flush and back-pressure.
        for (int i = 0; i < 3000; i++) begin
            randomize_id();
            rst = ($urandom % 64) == 0;
            ex_ready = ($urandom % 4) != 0;
            ex_flush = ($urandom % 8) == 0;
            next_cycle();
        end
        rst = 0; ex_flush = 0; ex_ready = 1;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
